// File: rtl/vector_stream_loader.sv
// Burst reader: fetches `length` words from a 1-cycle-latency memory port and
// streams them out through a 2-entry skid buffer with a last flag.
module vector_stream_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [LEN_WIDTH-1:0]  i_length,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0] o_mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
    output logic                  o_out_valid,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_last,
    input  logic                  i_out_ready
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_issued;
    logic [LEN_WIDTH-1:0]  r_popped;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic [1:0]            r_count;

    logic       w_pop;
    logic       w_cap;
    logic       w_last_issue;
    logic [2:0] w_occ;

    // Occupancy once this cycle's pop is retired; an in-flight read already owns a slot.
    assign w_pop        = o_out_valid && i_out_ready;
    assign w_cap        = r_inflight;
    assign w_occ        = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    assign o_mem_rd_en  = (r_state == S_FETCH) && (r_issued < r_len) && (w_occ < 3'd2);
    assign w_last_issue = o_mem_rd_en && (r_issued == r_len - LEN_WIDTH'(1));

    assign o_mem_rd_addr = r_base + ADDR_WIDTH'(r_issued);
    assign o_out_valid   = (r_count != 2'd0);
    assign o_out_data    = r_buf0;
    assign o_out_last    = o_out_valid && (r_popped == r_len - LEN_WIDTH'(1));
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_popped   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= o_mem_rd_en;
            if (o_mem_rd_en) r_issued <= r_issued + LEN_WIDTH'(1);
            if (w_pop)       r_popped <= r_popped + LEN_WIDTH'(1);
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_base   <= i_base_addr;
                    r_len    <= i_length;
                    r_issued <= '0;
                    r_popped <= '0;
                    r_state  <= (i_length == '0) ? S_DONE : S_FETCH;
                end
                S_FETCH: if (w_last_issue) r_state <= S_DRAIN;
                S_DRAIN: if (w_pop && o_out_last) r_state <= S_DONE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Entry 0 is always the head; entry 1 only fills when the head is stalled.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_buf0  <= '0;
            r_buf1  <= '0;
            r_count <= '0;
        end else begin
            case ({w_cap, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_buf0 <= i_mem_rd_data;
                    else                 r_buf1 <= i_mem_rd_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_buf0  <= r_buf1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_buf0 <= i_mem_rd_data;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= i_mem_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset)
        !(w_cap && !w_pop && r_count == 2'd2));

endmodule

// File: tb/tb_vector_stream_loader.sv
// Scoreboard bench for vector_stream_loader: expected words/addresses are queued
// at launch and matched against what the DUT issues and streams.
module tb_vector_stream_loader;
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [7:0]  i_base_addr;
    logic [7:0]  i_length;
    logic        o_busy, o_done, o_mem_rd_en;
    logic [7:0]  o_mem_rd_addr;
    logic [31:0] i_mem_rd_data;
    logic        o_out_valid;
    logic [31:0] o_out_data;
    logic        o_out_last;
    logic        i_out_ready;

    vector_stream_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LEN_WIDTH(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_length(i_length), .o_busy(o_busy), .o_done(o_done), .o_mem_rd_en(o_mem_rd_en),
        .o_mem_rd_addr(o_mem_rd_addr), .i_mem_rd_data(i_mem_rd_data), .o_out_valid(o_out_valid),
        .o_out_data(o_out_data), .o_out_last(o_out_last), .i_out_ready(i_out_ready)
    );

    always #5 i_clk = ~i_clk;

    // memory[i] = 0x1000_0000 + i, one cycle read latency
    always @(posedge i_clk) if (o_mem_rd_en) i_mem_rd_data <= 32'h1000_0000 + {24'd0, o_mem_rd_addr};

    typedef struct { logic [31:0] d; logic l; int t; } obs_t;
    obs_t        ob_q[$];
    logic [7:0]  rd_q[$];
    int          rd_t[$];
    logic [31:0] exp_d[$];
    logic [7:0]  exp_a[$];
    int n_chk, n_fail;
    int cyc, n_rd, n_pop, n_done, n_valid, n_unstable, max_occ, first_v, done_t;
    logic hold_v, hold_l;
    logic [31:0] hold_d;

    task automatic clr();
        ob_q.delete(); rd_q.delete(); rd_t.delete();
        cyc = 0; n_rd = 0; n_pop = 0; n_done = 0; n_valid = 0; n_unstable = 0;
        max_occ = 0; first_v = -1; done_t = -1; hold_v = 1'b0; hold_l = 1'b0; hold_d = '0;
    endtask

    // one clock: observe at negedge, return 1ns after the next rising edge
    task automatic step();
        @(negedge i_clk);
        if (o_mem_rd_en) begin rd_q.push_back(o_mem_rd_addr); rd_t.push_back(cyc); n_rd++; end
        if (o_out_valid) begin
            n_valid++;
            if (first_v < 0) first_v = cyc;
            if (hold_v && (o_out_data !== hold_d || o_out_last !== hold_l)) n_unstable++;
        end
        if (o_out_valid && i_out_ready) begin ob_q.push_back('{o_out_data, o_out_last, cyc}); n_pop++; end
        hold_v = o_out_valid && !i_out_ready; hold_d = o_out_data; hold_l = o_out_last;
        if (n_rd - n_pop > max_occ) max_occ = n_rd - n_pop;
        if (o_done) begin n_done++; done_t = cyc; end
        @(posedge i_clk); #1;
        cyc++;
    endtask

    task automatic launch(input logic [7:0] b, input logic [7:0] n);
        i_base_addr = b; i_length = n; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        clr();
        exp_d.delete(); exp_a.delete();
        for (int i = 0; i < int'(n); i++) begin
            exp_a.push_back(b + 8'(i));
            exp_d.push_back(32'h1000_0000 + {24'd0, 8'(b + 8'(i))});
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_start = 1'b0; i_base_addr = '0; i_length = '0; i_out_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        n_chk++; if ({o_busy, o_done, o_mem_rd_en, o_out_valid, o_out_last} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags got %b want 00000", {o_busy, o_done, o_mem_rd_en, o_out_valid, o_out_last}); end
        n_chk++; if (o_out_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", o_out_data); end
        n_chk++; if (o_mem_rd_addr !== 8'd0) begin n_fail++; $display("FAIL reset_addr got %h want 0", o_mem_rd_addr); end
        i_reset = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_basic();
        obs_t o; logic [31:0] e; logic [7:0] a; int k;
        i_out_ready = 1'b1;
        launch(8'h10, 8'd4);
        while (cyc < 40 && n_done == 0) step();
        n_chk++; if (n_done != 1) begin n_fail++; $display("FAIL basic_done got %0d pulses want 1", n_done); end
        n_chk++; if (done_t != 6) begin n_fail++; $display("FAIL basic_done_time got %0d want 6", done_t); end
        n_chk++; if (first_v != 2) begin n_fail++; $display("FAIL basic_first_valid got %0d want 2", first_v); end
        n_chk++; if (rd_t.size() != 4 || rd_t[0] != 0 || rd_t[3] != 3) begin
            n_fail++; $display("FAIL basic_rd_timing got %0d reads want 4 on cycles 0..3", rd_t.size()); end
        while (rd_q.size() > 0) begin
            a = rd_q.pop_front(); n_chk++;
            if (exp_a.size() == 0 || a !== exp_a[0]) begin n_fail++; $display("FAIL basic_addr got %h want %h", a, exp_a.size() != 0 ? exp_a[0] : 8'hxx); end
            if (exp_a.size() != 0) void'(exp_a.pop_front());
        end
        k = 0;
        while (ob_q.size() > 0) begin
            o = ob_q.pop_front(); n_chk++;
            if (exp_d.size() == 0) begin n_fail++; $display("FAIL basic_extra got %h want none", o.d); end
            else begin
                e = exp_d.pop_front();
                if (o.d !== e || o.l !== (exp_d.size() == 0) || o.t != k + 2) begin
                    n_fail++; $display("FAIL basic_word got %h/%b@%0d want %h/%b@%0d", o.d, o.l, o.t, e, exp_d.size() == 0, k + 2); end
            end
            k++;
        end
        n_chk++; if (exp_d.size() != 0) begin n_fail++; $display("FAIL basic_missing got %0d short want 0", exp_d.size()); end
        step();
        n_chk++; if (o_busy !== 1'b0 || n_done != 1) begin n_fail++; $display("FAIL basic_idle got busy=%b done=%0d want 0/1", o_busy, n_done); end
    endtask

    task automatic test_backpressure();
        obs_t o; logic [31:0] e;
        logic [5:0] pat;
        pat = 6'b101001;    // bit i = ready on cycle i%6: 1,0,0,1,0,1
        launch(8'h30, 8'd6);
        while (cyc < 80 && n_done == 0) begin i_out_ready = pat[cyc % 6]; step(); end
        i_out_ready = 1'b1;
        n_chk++; if (n_done != 1) begin n_fail++; $display("FAIL bp_done got %0d want 1", n_done); end
        n_chk++; if (n_unstable != 0) begin n_fail++; $display("FAIL bp_stable got %0d changes want 0", n_unstable); end
        n_chk++; if (max_occ > 2) begin n_fail++; $display("FAIL bp_occupancy got %0d want <=2", max_occ); end
        n_chk++; if (n_rd != 6) begin n_fail++; $display("FAIL bp_reads got %0d want 6", n_rd); end
        while (ob_q.size() > 0) begin
            o = ob_q.pop_front(); n_chk++;
            if (exp_d.size() == 0) begin n_fail++; $display("FAIL bp_extra got %h want none", o.d); end
            else begin
                e = exp_d.pop_front();
                if (o.d !== e || o.l !== (exp_d.size() == 0)) begin
                    n_fail++; $display("FAIL bp_word got %h/%b want %h/%b", o.d, o.l, e, exp_d.size() == 0); end
            end
        end
        n_chk++; if (exp_d.size() != 0) begin n_fail++; $display("FAIL bp_missing got %0d short want 0", exp_d.size()); end
    endtask

    task automatic test_empty();
        i_out_ready = 1'b1;
        launch(8'h50, 8'd0);
        repeat (5) step();
        n_chk++; if (n_rd != 0 || n_valid != 0) begin n_fail++; $display("FAIL empty_activity got rd=%0d valid=%0d want 0/0", n_rd, n_valid); end
        n_chk++; if (n_done != 1 || done_t != 0) begin n_fail++; $display("FAIL empty_done got %0d@%0d want 1@0", n_done, done_t); end
    endtask

    task automatic test_wrap();
        obs_t o; logic [31:0] e; logic [7:0] a;
        i_out_ready = 1'b1;
        launch(8'hFE, 8'd4);
        while (cyc < 40 && n_done == 0) step();
        n_chk++; if (n_done != 1) begin n_fail++; $display("FAIL wrap_done got %0d want 1", n_done); end
        while (rd_q.size() > 0) begin
            a = rd_q.pop_front(); n_chk++;
            if (exp_a.size() == 0 || a !== exp_a[0]) begin n_fail++; $display("FAIL wrap_addr got %h want %h", a, exp_a.size() != 0 ? exp_a[0] : 8'hxx); end
            if (exp_a.size() != 0) void'(exp_a.pop_front());
        end
        n_chk++; if (exp_a.size() != 0) begin n_fail++; $display("FAIL wrap_addr_missing got %0d short want 0", exp_a.size()); end
        while (ob_q.size() > 0) begin
            o = ob_q.pop_front(); n_chk++;
            if (exp_d.size() == 0) begin n_fail++; $display("FAIL wrap_extra got %h want none", o.d); end
            else begin
                e = exp_d.pop_front();
                if (o.d !== e || o.l !== (exp_d.size() == 0)) begin
                    n_fail++; $display("FAIL wrap_word got %h/%b want %h/%b", o.d, o.l, e, exp_d.size() == 0); end
            end
        end
        n_chk++; if (exp_d.size() != 0) begin n_fail++; $display("FAIL wrap_missing got %0d short want 0", exp_d.size()); end
    endtask

    task automatic test_reset_mid();
        obs_t o; logic [31:0] e;
        i_out_ready = 1'b1;
        launch(8'h60, 8'd8);
        while (cyc < 40 && n_pop < 3) step();
        n_chk++; if (n_pop != 3) begin n_fail++; $display("FAIL rstmid_progress got %0d words want 3", n_pop); end
        i_reset = 1'b0;
        #1;
        n_chk++; if ({o_busy, o_done, o_mem_rd_en, o_out_valid, o_out_last} !== 5'b0 || o_out_data !== 32'd0 || o_mem_rd_addr !== 8'd0) begin
            n_fail++; $display("FAIL rstmid_outputs got %b/%h/%h want 00000/0/0",
                {o_busy, o_done, o_mem_rd_en, o_out_valid, o_out_last}, o_out_data, o_mem_rd_addr); end
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        clr();
        repeat (8) step();
        n_chk++; if (n_valid != 0 || n_done != 0 || n_rd != 0) begin
            n_fail++; $display("FAIL rstmid_quiet got valid=%0d done=%0d rd=%0d want 0/0/0", n_valid, n_done, n_rd); end
        launch(8'h20, 8'd2);
        while (cyc < 40 && n_done == 0) step();
        n_chk++; if (n_done != 1) begin n_fail++; $display("FAIL rstmid_new_done got %0d want 1", n_done); end
        while (ob_q.size() > 0) begin
            o = ob_q.pop_front(); n_chk++;
            if (exp_d.size() == 0) begin n_fail++; $display("FAIL rstmid_extra got %h want none", o.d); end
            else begin
                e = exp_d.pop_front();
                if (o.d !== e || o.l !== (exp_d.size() == 0)) begin
                    n_fail++; $display("FAIL rstmid_word got %h/%b want %h/%b", o.d, o.l, e, exp_d.size() == 0); end
            end
        end
        n_chk++; if (exp_d.size() != 0) begin n_fail++; $display("FAIL rstmid_missing got %0d short want 0", exp_d.size()); end
    endtask

    task automatic test_start_busy();
        obs_t o; logic [31:0] e;
        i_out_ready = 1'b1;
        launch(8'h70, 8'd3);
        i_base_addr = 8'h40; i_length = 8'd5;
        // start held during FETCH (cycle 1) and during the DONE cycle (cycle 5)
        while (cyc < 12) begin i_start = (cyc == 1 || cyc == 5); step(); end
        i_start = 1'b0;
        n_chk++; if (n_done != 1) begin n_fail++; $display("FAIL busy_done got %0d pulses want 1", n_done); end
        n_chk++; if (n_rd != 3) begin n_fail++; $display("FAIL busy_reads got %0d want 3", n_rd); end
        n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle got %b want 0", o_busy); end
        while (ob_q.size() > 0) begin
            o = ob_q.pop_front(); n_chk++;
            if (exp_d.size() == 0) begin n_fail++; $display("FAIL busy_extra got %h want none", o.d); end
            else begin
                e = exp_d.pop_front();
                if (o.d !== e || o.l !== (exp_d.size() == 0)) begin
                    n_fail++; $display("FAIL busy_word got %h/%b want %h/%b", o.d, o.l, e, exp_d.size() == 0); end
            end
        end
        n_chk++; if (exp_d.size() != 0) begin n_fail++; $display("FAIL busy_missing got %0d short want 0", exp_d.size()); end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        clr();
        test_reset();
        test_basic();
        test_backpressure();
        test_empty();
        test_wrap();
        test_reset_mid();
        test_start_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vector_stream_loader.md
Name: vector_stream_loader

Overview:
- Upstream feeder for the 32-bit registered data stage.
- On a start pulse, reads `length` consecutive words from a unified-buffer-style synchronous read port (1-cycle read latency), starting at `base_addr`.
- Presents the words in order on a valid/ready stream with a last flag.
- Absorbs downstream backpressure with a 2-entry skid buffer, so no read data is ever dropped.

Parameters:
- DATA_WIDTH, 32, width of memory words and stream data.
- ADDR_WIDTH, 8, width of memory read address.
- LEN_WIDTH, 8, width of burst length field. Max burst is 2^LEN_WIDTH-1 words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
- start  input  1  burst request, sampled at a clock edge; ignored while busy=1.
- base_addr  input  ADDR_WIDTH  first read address, captured when start is accepted.
- length  input  LEN_WIDTH  number of words, captured when start is accepted; 0 = empty burst.
- busy  output  1  high from the cycle after start is accepted until done pulses.
- done  output  1  one-cycle pulse at burst completion.
- mem_rd_en  output  1  read strobe to memory.
- mem_rd_addr  output  ADDR_WIDTH  read address, valid when mem_rd_en=1.
- mem_rd_data  input  DATA_WIDTH  read data; valid exactly one cycle after mem_rd_en.
- out_valid  output  1  stream word available.
- out_data  output  DATA_WIDTH  stream word.
- out_last  output  1  marks the final word of the burst; qualified by out_valid.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - busy, done, mem_rd_en, out_valid, out_last = 0.
  - out_data = 0, mem_rd_addr = 0.
  - Skid buffer emptied; issue and pop counters cleared; in-flight flag cleared.
  - Reset mid-burst abandons the burst. No done pulse, and no stale word appears after reset deasserts.
- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE: start=1 && length!=0 → FETCH, capturing base_addr and length. start=1 && length==0 → DONE, with no memory reads.
  - FETCH: issue reads. After the last read is issued → DRAIN.
  - DRAIN: wait for the final word to be popped. The pop handshake with out_last=1 → DONE.
  - DONE: done=1 for exactly this one cycle → IDLE. busy=0 in IDLE only.
- Read issue:
  - mem_rd_en is combinational: (state==FETCH) && (issued < length) && (buf_count + inflight - pop) < 2.
  - inflight = mem_rd_en of the previous cycle.
  - pop = out_valid && out_ready.
  - This gives sustained 1 word/cycle when out_ready is held high.
- Address:
  - mem_rd_addr = base_addr + issued, modulo 2^ADDR_WIDTH.
  - Wrap from max address to 0 is silent and legal.
- Capture: mem_rd_data is written into the skid buffer on the edge after each read. The buffer never overflows by construction; an overflow is an assertion failure.
- Stream:
  - out_valid = buf_count != 0.
  - out_data = head entry.
  - out_last = (popped == length-1) && out_valid.
  - While out_valid=1 && out_ready=0, out_data and out_last hold stable.
  - Words leave in strictly increasing address order, with no duplicates and no drops.
- Latency:
  - Start accepted at edge k: first mem_rd_en is high in cycle k→k+1, first out_valid at edge k+2.
  - done pulses in the cycle after the last-word handshake.
- Simultaneous events:
  - Capture and pop in the same cycle leave buf_count unchanged.
  - start during busy or during the DONE cycle is ignored; the next burst needs start in IDLE.

Test Plan:
- Basic burst: memory[i]=0x1000_0000+i; base=0x10, length=4, out_ready=1.
  - Reads issued at addresses 0x10..0x13 on 4 consecutive cycles.
  - out_data = 0x10000010..0x10000013 on 4 consecutive cycles, out_last only on the 4th.
  - done pulses 1 cycle later; first out_valid 2 cycles after start.
- Backpressure: length=6, out_ready toggling 1,0,0,1,0,1,...
  - All 6 words delivered in order with none lost.
  - out_data is stable during stalls; mem_rd_en never raises buf_count above 2.
- Empty burst: length=0.
  - No mem_rd_en; out_valid stays 0; done pulses one cycle after start.
- Address wrap: base=0xFE, length=4.
  - Read addresses 0xFE, 0xFF, 0x00, 0x01; data delivered in that order.
- Reset mid-burst: length=8, reset driven low after the 3rd word.
  - All outputs 0 immediately.
  - After release, out_valid stays 0 with no done pulse.
  - A new burst with base=0x20, length=2 completes correctly.
- Start while busy: a second start with base=0x40 is issued during a length=3 burst.
  - It is ignored; only the 3 original words are emitted and a single done pulse occurs.
